mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter and sequencer that shares the single-port 14-bit-address / 10-bit-data RAM+ROM memory between NREQ requesters, e.g. instruction fetch and data access. It sits between the requesters and the memory and owns every memory control signal. Each access is a fixed three-phase sequence: issue, capture, respond. The block blocks writes into the ROM half (addr[13]=1) and flags them as errors.

## Interface
- NREQ, 2, number of requesters (2..4)
- AW, 14, address width; bit AW-1 selects ROM
- DW, 10, data width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  access request per requester; held until its done
- we  in  NREQ  1=write, 0=read; held with req
- addr  in  NREQ×AW  per-requester address; held with req
- wdata  in  NREQ×DW  per-requester write data; held with req
- gnt  out  NREQ  one-hot pulse in the issue cycle of the winning requester
- done  out  NREQ  one-hot pulse, access complete
- rdata  out  DW  read data, valid while done is nonzero
- err  out  1  pulses with done when the completed access was a dropped ROM write
- busy  out  1  state ≠ IDLE
- mem_addr  out  AW  to memory addr
- mem_indata  out  DW  to memory indata
- mem_write  out  1  to memory write
- mem_read  out  1  to memory read
- mem_outdata  in  DW  from memory outdata

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE**
  - Eligible set = req with the bit of any requester whose done is high this cycle masked off.
  - If the set is non-empty, pick the winner round-robin starting at (last+1) mod NREQ.
  - Latch the winner's index, addr, we and wdata, update last, and go to ISSUE.
- **ISSUE**
  - mem_addr = latched addr; mem_indata = latched wdata; gnt[winner]=1.
  - mem_write = we & ~addr[AW-1].
  - mem_read = ~we. This is asserted for ROM reads as well; it is harmless.
  - Next state: CAPTURE.
- **CAPTURE**
  - mem_addr stays at the latched addr; mem_read=mem_write=0.
  - At the clock edge, the rdata register loads mem_outdata (RAM data registered by the memory, or ROM data combinational on the held address).
  - err register loads we & addr[AW-1].
  - Next state: RESP.
- **RESP**
  - done[winner]=1; rdata and err are driven from their registers.
  - Next state: IDLE.
- rdata holds its value until the next capture. It is meaningful only while done is nonzero.
  - For writes, rdata = mem_outdata sampled in CAPTURE and is don't-care for the requester.
- Dropped ROM write: the sequence still runs its full length; mem_write is never asserted; err=1 with done.
- last resets to NREQ-1, so requester 0 has first priority.
- Reset values: all outputs 0, state IDLE, latched fields 0, last=NREQ-1.

## Timing
- Request seen in IDLE at cycle T: gnt and mem_read/mem_write at T+1, capture at T+2, done/rdata at T+3.
- Earliest next issue is T+5, so a single requester gets one access per 4 cycles.
- Between two back-to-back accesses there is one IDLE cycle, and it coincides with the done cycle only in the sense that done is produced by RESP. The next arbitration happens in the IDLE cycle following RESP.
  - A requester must deassert req the cycle after done or it is re-queued. The mask in IDLE covers a done that is still visible in that cycle.
- req or other inputs changing mid-sequence have no effect, because the fields were latched in IDLE.
- Simultaneous requests in IDLE: exactly one grant. The others wait, and their req stays high.
- rst_n low at any time, including mid-ISSUE: state goes to IDLE and all outputs go to 0 immediately.
  - A write whose issue edge has already passed may have committed; this is not specified further.
  - No done is produced for the aborted access.
- mem_addr, mem_read and mem_write are decoded from registered state only: no combinational path from req to the memory.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, CAPTURE, RESP);
  - the default constants AW=14, DW=10, ROM_BIT=13.
- One sub-module, rr_picker: combinational round-robin selector. Inputs are the eligible vector and last; outputs are the one-hot winner, the index, and valid.
- The FSM and the latches live in the top module.

## Test plan
- RAM preloaded with 0x2A5 at 0x0005; req[0] reads 0x0005 → gnt[0] at T+1, done[0] at T+3, rdata=0x2A5, err=0.
- req[1] writes 0x155 to 0x0100, then reads 0x0100 → mem_write for exactly one cycle, then read returns rdata=0x155.
- req[0] and req[1] held continuously, addresses 0x0010 and 0x0011 → grants alternate 0,1,0,1. Each done arrives 4 cycles after the previous one.
- ROM word 0x2000 = 0x3C3; req[0] writes 0x000 to 0x2000 → mem_write stays 0 throughout, done[0] with err=1; a subsequent read of 0x2000 returns 0x3C3.
- rst_n pulsed low during CAPTURE → all outputs 0 in that cycle, no done; a fresh read of 0x0005 afterwards → correct result, requester 0 served first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned AW      = 14;
   localparam int unsigned DW      = 10;
   localparam int unsigned ROM_BIT = 13;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first eligible requester after 'last'.
module rr_picker #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IW   = 1
) (
   input  logic [NREQ-1:0] elig,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] win_oh_c,
   output logic [IW-1:0]   win_idx_c,
   output logic            valid_c
);

   // Walk from farthest to nearest so the nearest eligible requester wins.
   always_comb begin
      win_oh_c  = '0;
      win_idx_c = '0;
      valid_c   = 1'b0;
      for (int unsigned i = NREQ; i >= 1; i--) begin
         if (elig[(32'(last) + i) % NREQ]) begin
            win_oh_c                         = '0;
            win_oh_c[(32'(last) + i) % NREQ] = 1'b1;
            win_idx_c                        = IW'((32'(last) + i) % NREQ);
            valid_c                          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM+ROM port between NREQ requesters;
// every access runs issue/capture/respond and ROM writes are dropped.
module mem_port_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = mem_arb_pkg::AW,
   parameter int unsigned DW   = mem_arb_pkg::DW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [DW-1:0]     rdata,
   output logic              err,
   output logic              busy,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_indata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DW-1:0]     mem_outdata
);

   import mem_arb_pkg::state_e, mem_arb_pkg::IDLE, mem_arb_pkg::ISSUE,
          mem_arb_pkg::CAPTURE, mem_arb_pkg::RESP;

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e          state;
   logic [IW-1:0]   last;
   logic [NREQ-1:0] win_oh;
   logic            lat_we;

   logic [NREQ-1:0] elig_c;
   logic [NREQ-1:0] pick_oh_c;
   logic [IW-1:0]   pick_idx_c;
   logic            pick_valid_c;
   logic [AW-1:0]   sel_addr_c;
   logic [DW-1:0]   sel_wdata_c;
   logic            sel_we_c;

   // A requester still showing done this cycle is not re-granted.
   assign elig_c      = req & ~done;
   assign sel_addr_c  = addr[32'(pick_idx_c)*AW +: AW];
   assign sel_wdata_c = wdata[32'(pick_idx_c)*DW +: DW];
   assign sel_we_c    = we[pick_idx_c];

   rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .elig      (elig_c),
      .last      (last),
      .win_oh_c  (pick_oh_c),
      .win_idx_c (pick_idx_c),
      .valid_c   (pick_valid_c)
   );

   // Sequencer; memory controls come only from registers, never from req.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last       <= IW'(NREQ - 1);
         win_oh     <= '0;
         lat_we     <= 1'b0;
         gnt        <= '0;
         done       <= '0;
         rdata      <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
         mem_addr   <= '0;
         mem_indata <= '0;
         mem_write  <= 1'b0;
         mem_read   <= 1'b0;
      end else begin
         gnt       <= '0;
         done      <= '0;
         err       <= 1'b0;
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid_c) begin
                  state      <= ISSUE;
                  busy       <= 1'b1;
                  last       <= pick_idx_c;
                  win_oh     <= pick_oh_c;
                  lat_we     <= sel_we_c;
                  mem_addr   <= sel_addr_c;
                  mem_indata <= sel_wdata_c;
                  gnt        <= pick_oh_c;
                  mem_read   <= ~sel_we_c;
                  mem_write  <= sel_we_c & ~sel_addr_c[AW-1];
               end
            end
            ISSUE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               state <= RESP;
               rdata <= mem_outdata;
               err   <= lat_we & mem_addr[AW-1];
               done  <= win_oh;
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-RAM / combinational-ROM model.
module tb_mem_port_arbiter;

   localparam int unsigned NREQ = 2;
   localparam int unsigned AW   = 14;
   localparam int unsigned DW   = 10;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   we;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [DW-1:0]     rdata;
   logic              err;
   logic              busy;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_indata;
   logic              mem_write;
   logic              mem_read;
   logic [DW-1:0]     mem_outdata;

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int cyc    = 0;

   logic [DW-1:0] ram [0:8191];
   logic [DW-1:0] ram_q;
   logic [DW-1:0] rom_data;

   mem_port_arbiter #(
      .NREQ (NREQ),
      .AW   (AW),
      .DW   (DW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .we          (we),
      .addr        (addr),
      .wdata       (wdata),
      .gnt         (gnt),
      .done        (done),
      .rdata       (rdata),
      .err         (err),
      .busy        (busy),
      .mem_addr    (mem_addr),
      .mem_indata  (mem_indata),
      .mem_write   (mem_write),
      .mem_read    (mem_read),
      .mem_outdata (mem_outdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: registered read, preloaded on reset; ROM: combinational on address.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram[13'h0005] <= 10'h2A5;
         ram[13'h0010] <= 10'h0AA;
         ram[13'h0011] <= 10'h0BB;
         ram_q         <= '0;
      end else begin
         if (mem_write) ram[mem_addr[12:0]] <= mem_indata;
         if (mem_read)  ram_q <= ram[mem_addr[12:0]];
      end
   end

   assign rom_data    = (mem_addr[12:0] == 13'h0000) ? 10'h3C3 : 10'h000;
   assign mem_outdata = mem_addr[13] ? rom_data : ram_q;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_write) wr_cnt <= wr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One isolated access, entered in IDLE at a falling edge, leaves in IDLE.
   task automatic do_access(input int idx, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                            input logic exp_err, input int exp_wr, input string tag);
      logic [NREQ-1:0] oh;
      int              wr0;
      oh           = '0;
      oh[idx]      = 1'b1;
      req[idx]     = 1'b1;
      we[idx]      = w;
      addr[idx*AW +: AW]  = a;
      wdata[idx*DW +: DW] = d;
      wr0          = wr_cnt;
      @(negedge clk);
      check({tag, ".gnt"}, 32'(gnt), 32'(oh));
      check({tag, ".mem_read"}, 32'(mem_read), 32'(!w));
      check({tag, ".mem_write"}, 32'(mem_write), 32'(w & ~a[13]));
      check({tag, ".mem_addr"}, 32'(mem_addr), 32'(a));
      check({tag, ".busy"}, 32'(busy), 32'd1);
      if (w) check({tag, ".mem_indata"}, 32'(mem_indata), 32'(d));
      @(negedge clk);
      check({tag, ".cap_done"}, 32'(done), 32'd0);
      check({tag, ".cap_ctl"}, 32'({gnt, mem_read, mem_write}), 32'd0);
      @(negedge clk);
      check({tag, ".done"}, 32'(done), 32'(oh));
      if (!w) check({tag, ".rdata"}, 32'(rdata), 32'(exp_rd));
      check({tag, ".err"}, 32'(err), 32'(exp_err));
      check({tag, ".writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
      req[idx] = 1'b0;
      @(negedge clk);
      check({tag, ".idle"}, 32'({done, err, busy}), 32'd0);
   endtask

   initial begin
      int t_prev;
      int n;
      logic [NREQ-1:0] exp_oh;

      req   = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      rst_n = 1'b0;
      t_prev = 0;
      repeat (2) @(negedge clk);
      check("reset.outs", 32'({gnt, done, err, busy, mem_write, mem_read}), 32'd0);
      check("reset.rdata", 32'(rdata), 32'd0);
      check("reset.mem_addr", 32'(mem_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_access(0, 1'b0, 14'h0005, 10'h000, 10'h2A5, 1'b0, 0, "rd5");
      do_access(1, 1'b1, 14'h0100, 10'h155, 10'h000, 1'b0, 1, "wr100");
      do_access(1, 1'b0, 14'h0100, 10'h000, 10'h155, 1'b0, 0, "rd100");

      // Both requesters held: grants alternate, one done every 4 cycles.
      we    = 2'b00;
      addr  = {14'h0011, 14'h0010};
      req   = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
         n = 0;
         while (gnt == '0 && n < 8) begin
            @(negedge clk);
            n++;
         end
         check("rr.gnt", 32'(gnt), 32'(exp_oh));
         repeat (2) @(negedge clk);
         check("rr.done", 32'(done), 32'(exp_oh));
         check("rr.rdata", 32'(rdata), (k % 2 == 0) ? 32'h0AA : 32'h0BB);
         if (k > 0) check("rr.gap", 32'(cyc - t_prev), 32'd4);
         t_prev = cyc;
      end
      req = '0;
      @(negedge clk);

      do_access(0, 1'b1, 14'h2000, 10'h000, 10'h000, 1'b1, 0, "romwr");
      do_access(0, 1'b0, 14'h2000, 10'h000, 10'h3C3, 1'b0, 0, "romrd");

      // Reset in the middle of an access.
      we   = 2'b00;
      addr = {14'h0100, 14'h0005};
      req  = 2'b01;
      @(negedge clk);
      check("abort.gnt", 32'(gnt), 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort.outs", 32'({gnt, done, err, busy, mem_write, mem_read}), 32'd0);
      check("abort.rdata", 32'(rdata), 32'd0);
      check("abort.mem_addr", 32'(mem_addr), 32'd0);
      req = '0;
      @(negedge clk);
      check("abort.nodone1", 32'(done), 32'd0);
      @(negedge clk);
      check("abort.nodone2", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      req = 2'b11;
      @(negedge clk);
      check("post.gnt0", 32'(gnt), 32'h1);
      repeat (2) @(negedge clk);
      check("post.done0", 32'(done), 32'h1);
      check("post.rdata0", 32'(rdata), 32'h2A5);
      req[0] = 1'b0;
      repeat (2) @(negedge clk);
      check("post.gnt1", 32'(gnt), 32'h2);
      repeat (2) @(negedge clk);
      check("post.done1", 32'(done), 32'h2);
      check("post.rdata1", 32'(rdata), 32'h155);
      req[1] = 1'b0;
      repeat (2) @(negedge clk);
      check("post.idle", 32'({busy, done, gnt}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
